mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instruction opcode, instr[31:26], taken from the instruction register.
REQ-005 funct  in  6  R-type function field, instr[5:0].
REQ-006 zero  in  1  ALU result equals zero.
REQ-007 ltez  in  1  register operand A is <= 0 (signed), used by BLEZ.
REQ-008 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 memwrite  out  1  data memory write strobe.
REQ-010 irwrite  out  1  instruction register load enable.
REQ-011 regdst  out  1  write register select: 0 = rt, 1 = rd.
REQ-012 memtoreg  out  1  writeback select: 0 = ALUOut, 1 = Data register.
REQ-013 regwrite  out  1  register file write enable.
REQ-014 alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 alusrcb  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
REQ-016 alucontrol  out  4  ALU operation: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111.
REQ-017 pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-018 pcen  out  1  PC load enable.
REQ-019 state  out  4  current FSM state, exposed for debug and verification.

Function
REQ-020 The FSM SHALL have states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11 and BLEZEX=12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-021 Transitions: FETCH->DECODE; DECODE by op: 100011 (lw) and 101011 (sw) -> MEMADR, 000000 -> RTYPEEX, 000100 -> BEQEX, 000110 -> BLEZEX, 001000 -> ADDIEX, 000010 -> JEX, any other op -> FETCH.
REQ-022 Further transitions: MEMADR -> MEMRD if op=lw, MEMWR if op=sw; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BLEZEX and JEX -> FETCH.
REQ-023 Outputs SHALL be Moore (decoded from state only), except pcen, which also depends on zero and ltez; every output not listed for a state SHALL be 0, and alucontrol SHALL default to ADD.
REQ-024 FETCH outputs: iord=0, irwrite=1, alusrca=0, alusrcb=01, ADD, pcsrc=00, pcen=1.
REQ-025 DECODE outputs: alusrca=0, alusrcb=11, ADD (precomputes the branch target).
REQ-026 MEMADR and ADDIEX outputs: alusrca=1, alusrcb=10, ADD.
REQ-027 MEMRD outputs: iord=1. MEMWR outputs: iord=1, memwrite=1.
REQ-028 MEMWB outputs: regdst=0, memtoreg=1, regwrite=1. ADDIWB outputs: regdst=0, memtoreg=0, regwrite=1. RTYPEWB outputs: regdst=1, memtoreg=0, regwrite=1.
REQ-029 RTYPEEX outputs: alusrca=1, alusrcb=00, alucontrol decoded from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
REQ-030 An unrecognised funct in RTYPEEX SHALL drive ADD and transition to FETCH, skipping RTYPEWB, so no register write occurs.
REQ-031 BEQEX outputs: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen=zero.
REQ-032 BLEZEX outputs: same as BEQEX except pcen=ltez.
REQ-033 JEX outputs: pcsrc=10, pcen=1.
REQ-034 Instruction latency in cycles, FETCH included: lw 5; sw, R-type and addi 4; beq, blez and j 3; illegal op 2.
REQ-035 op and funct changes outside DECODE, MEMADR and RTYPEEX SHALL have no effect on outputs or state.

Reset
REQ-036 reset high at a rising edge SHALL force state=FETCH, overriding any transition, including mid-instruction.
REQ-037 While state=FETCH after reset, outputs SHALL be the FETCH values in REQ-024.
REQ-038 No memwrite or regwrite pulse SHALL occur in the cycle following the reset edge.

Verification
REQ-039 lw (op=100011) from reset: states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; memwrite never 1.
REQ-040 R-type SUB (op=0, funct=100010): states 0,1,6,7,0; alucontrol=0110 in state 6; regdst=1 and regwrite=1 in state 7.
REQ-041 beq with zero=1 then zero=0: pcen=1 and pcsrc=01 in BEQEX only when zero=1; blez with ltez=1 gives pcen=1, with ltez=0 gives pcen=0.
REQ-042 sw, then reset asserted while state=MEMADR: next state=FETCH, and memwrite stays 0 throughout.
REQ-043 Illegal op=111111: states 0,1,0 with no write strobes; R-type with funct=000000: states 0,1,6,0 and regwrite stays 0.
REQ-044 j (op=000010): states 0,1,11,0; pcsrc=10 and pcen=1 in state 11.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit.
// A thirteen-state Moore FSM sequences each instruction through fetch,
// decode and execute steps. Datapath controls are decoded from the current
// state. The exceptions are pcen, which also follows zero/ltez in the branch
// states, and alucontrol in RTYPEEX, which follows funct.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       ltez,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BLEZEX  = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // R-type function field to ALU operation. Unknown codes fall back to ADD.
  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_ADD;
    endcase
  endfunction

  // True for the function codes that may reach register writeback.
  function automatic logic funct_known(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_known = 1'b1;
      default: funct_known = 1'b0;
    endcase
  endfunction

  state_t state_r;
  state_t next_state_s;

  // State register. Reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. op is consulted only in DECODE and MEMADR, and funct only in RTYPEEX.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_RTYPEEX;
          OP_BEQ:       next_state_s = S_BEQEX;
          OP_BLEZ:      next_state_s = S_BLEZEX;
          OP_ADDI:      next_state_s = S_ADDIEX;
          OP_J:         next_state_s = S_JEX;
          default:      next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          next_state_s = S_MEMRD;
        end else if (op == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMRD:   next_state_s = S_MEMWB;
      S_RTYPEEX: begin
        if (funct_known(funct)) begin
          next_state_s = S_RTYPEWB;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_ADDIEX:  next_state_s = S_ADDIWB;
      default:   next_state_s = S_FETCH;
    endcase
  end

  // Output decode. Every control is inactive unless the current state asserts it.
  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    case (state_r)
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcen    = 1'b1;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu(funct);
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
      end
      S_BLEZEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = ltez;
      end
      S_JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: begin
        pcen = 1'b0;
      end
    endcase
  end

  assign state = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller. A table of per-cycle input/expected-output records
// is played through a scoreboard queue. Hand-written sequences then cover a
// held reset and the per-instruction latency.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       ltez;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb;
  logic [3:0] alucontrol;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [3:0] state;
  logic [15:0] act;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .ltez(ltez),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen), .state(state)
  );

  assign act = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, alucontrol, pcsrc, pcen};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BLZ = 6'b000110;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] ILL = 6'b111111;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_SLT = 4'b0111;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       ltez;
    logic [3:0] st;
    logic [15:0] out;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [15:0] out;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   nvec;
  int   nmis;

  logic [15:0] o_fetch, o_dec, o_madr, o_mrd, o_mwr, o_mwb, o_awb, o_rwb;
  logic [15:0] o_br_t, o_br_f, o_j;

  function automatic logic [15:0] mk(input logic io, input logic mw, input logic ir,
                                     input logic rd, input logic mt, input logic rw,
                                     input logic sa, input logic [1:0] sb2,
                                     input logic [3:0] alu, input logic [1:0] ps,
                                     input logic pe);
    return {io, mw, ir, rd, mt, rw, sa, sb2, alu, ps, pe};
  endfunction

  task automatic add_vec(input logic r, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input logic l, input logic [3:0] st,
                         input logic [15:0] out);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.ltez = l; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  task automatic add_rtype(input logic [5:0] f, input logic [3:0] alu);
    add_vec(1'b0, RT, f, 1'b0, 1'b0, 4'd1, o_dec);
    add_vec(1'b0, RT, f, 1'b0, 1'b0, 4'd6, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, alu, 2'b00, 1'b0));
    add_vec(1'b0, RT, f, 1'b0, 1'b0, 4'd7, o_rwb);
    add_vec(1'b0, RT, f, 1'b0, 1'b0, 4'd0, o_fetch);
  endtask

  task automatic check_out(input string name, input int idx, input logic [3:0] st_exp,
                           input logic [15:0] out_exp);
    nvec++;
    if (state !== st_exp) begin
      nmis++;
      $display("FAIL %s[%0d] state: got %0d, expected %0d", name, idx, state, st_exp);
    end
    if (act !== out_exp) begin
      nmis++;
      $display("FAIL %s[%0d] outputs: got %b, expected %b", name, idx, act, out_exp);
    end
  endtask

  task automatic latency(input logic [5:0] o, input logic [5:0] f, input int exp_lat,
                         input string name);
    int cyc;
    @(negedge clk);
    reset = 1'b0; op = o; funct = f; zero = 1'b0; ltez = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (state !== 4'd0 && cyc < 20);
    nvec++;
    if (cyc != exp_lat) begin
      nmis++;
      $display("FAIL latency_%s: got %0d cycles, expected %0d", name, cyc, exp_lat);
    end
  endtask

  initial begin
    exp_t e;
    nvec = 0;
    nmis = 0;
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; ltez = 1'b0;

    o_fetch = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, A_ADD, 2'b00, 1'b1);
    o_dec   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, A_ADD, 2'b00, 1'b0);
    o_madr  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, A_ADD, 2'b00, 1'b0);
    o_mrd   = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, A_ADD, 2'b00, 1'b0);
    o_mwr   = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, A_ADD, 2'b00, 1'b0);
    o_mwb   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, A_ADD, 2'b00, 1'b0);
    o_awb   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, A_ADD, 2'b00, 1'b0);
    o_rwb   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, A_ADD, 2'b00, 1'b0);
    o_br_t  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, A_SUB, 2'b01, 1'b1);
    o_br_f  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, A_SUB, 2'b01, 1'b0);
    o_j     = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, A_ADD, 2'b10, 1'b1);

    // reset, then lw; op is noise outside DECODE/MEMADR
    add_vec(1'b1, LW,  6'd0, 1'b0, 1'b0, 4'd0, o_fetch);
    add_vec(1'b0, ILL, 6'd5, 1'b0, 1'b0, 4'd1, o_dec);
    add_vec(1'b0, LW,  6'd0, 1'b0, 1'b0, 4'd2, o_madr);
    add_vec(1'b0, LW,  6'd0, 1'b0, 1'b0, 4'd3, o_mrd);
    add_vec(1'b0, SW,  6'd9, 1'b1, 1'b1, 4'd4, o_mwb);
    add_vec(1'b0, RT,  6'd0, 1'b0, 1'b0, 4'd0, o_fetch);
    // sw
    add_vec(1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd1, o_dec);
    add_vec(1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd2, o_madr);
    add_vec(1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd5, o_mwr);
    add_vec(1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd0, o_fetch);
    // R-type for each known funct
    add_rtype(6'b100010, A_SUB);
    add_rtype(6'b100000, A_ADD);
    add_rtype(6'b100100, A_AND);
    add_rtype(6'b100101, A_OR);
    add_rtype(6'b101010, A_SLT);
    // R-type with unknown funct skips writeback
    add_vec(1'b0, RT, 6'b000000, 1'b0, 1'b0, 4'd1, o_dec);
    add_vec(1'b0, RT, 6'b000000, 1'b0, 1'b0, 4'd6,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, A_ADD, 2'b00, 1'b0));
    add_vec(1'b0, RT, 6'b000000, 1'b0, 1'b0, 4'd0, o_fetch);
    // beq taken / not taken, blez taken / not taken
    add_vec(1'b0, BEQ, 6'd0, 1'b1, 1'b0, 4'd1, o_dec);
    add_vec(1'b0, BEQ, 6'd0, 1'b1, 1'b0, 4'd8, o_br_t);
    add_vec(1'b0, BEQ, 6'd0, 1'b1, 1'b0, 4'd0, o_fetch);
    add_vec(1'b0, BEQ, 6'd0, 1'b0, 1'b1, 4'd1, o_dec);
    add_vec(1'b0, BEQ, 6'd0, 1'b0, 1'b1, 4'd8, o_br_f);
    add_vec(1'b0, BEQ, 6'd0, 1'b0, 1'b1, 4'd0, o_fetch);
    add_vec(1'b0, BLZ, 6'd0, 1'b0, 1'b1, 4'd1, o_dec);
    add_vec(1'b0, BLZ, 6'd0, 1'b0, 1'b1, 4'd12, o_br_t);
    add_vec(1'b0, BLZ, 6'd0, 1'b0, 1'b1, 4'd0, o_fetch);
    add_vec(1'b0, BLZ, 6'd0, 1'b1, 1'b0, 4'd1, o_dec);
    add_vec(1'b0, BLZ, 6'd0, 1'b1, 1'b0, 4'd12, o_br_f);
    add_vec(1'b0, BLZ, 6'd0, 1'b1, 1'b0, 4'd0, o_fetch);
    // addi, j, illegal op
    add_vec(1'b0, ADI, 6'd0, 1'b0, 1'b0, 4'd1, o_dec);
    add_vec(1'b0, ADI, 6'd0, 1'b0, 1'b0, 4'd9, o_madr);
    add_vec(1'b0, ADI, 6'd0, 1'b0, 1'b0, 4'd10, o_awb);
    add_vec(1'b0, ADI, 6'd0, 1'b0, 1'b0, 4'd0, o_fetch);
    add_vec(1'b0, JMP, 6'd0, 1'b0, 1'b0, 4'd1, o_dec);
    add_vec(1'b0, JMP, 6'd0, 1'b0, 1'b0, 4'd11, o_j);
    add_vec(1'b0, JMP, 6'd0, 1'b0, 1'b0, 4'd0, o_fetch);
    add_vec(1'b0, ILL, 6'd0, 1'b0, 1'b0, 4'd1, o_dec);
    add_vec(1'b0, ILL, 6'd0, 1'b0, 1'b0, 4'd0, o_fetch);
    // reset mid-instruction: sw in MEMADR, lw in DECODE
    add_vec(1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd1, o_dec);
    add_vec(1'b0, SW, 6'd0, 1'b0, 1'b0, 4'd2, o_madr);
    add_vec(1'b1, SW, 6'd0, 1'b0, 1'b0, 4'd0, o_fetch);
    add_vec(1'b0, LW, 6'd0, 1'b0, 1'b0, 4'd1, o_dec);
    add_vec(1'b1, LW, 6'd0, 1'b0, 1'b0, 4'd0, o_fetch);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
      zero = vecs[i].zero; ltez = vecs[i].ltez;
      e.idx = i; e.st = vecs[i].st; e.out = vecs[i].out;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_out("vec", e.idx, e.st, e.out);
    end

    // reset held for several cycles keeps FETCH outputs
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      reset = 1'b1; op = LW; zero = 1'b1; ltez = 1'b1;
      @(posedge clk);
      #1;
      check_out("reset_hold", k, 4'd0, o_fetch);
    end

    // instruction latencies, FETCH included
    latency(LW,  6'd0,      5, "lw");
    latency(SW,  6'd0,      4, "sw");
    latency(RT,  6'b100000, 4, "rtype");
    latency(ADI, 6'd0,      4, "addi");
    latency(BEQ, 6'd0,      3, "beq");
    latency(BLZ, 6'd0,      3, "blez");
    latency(JMP, 6'd0,      3, "j");
    latency(ILL, 6'd0,      2, "illegal");
    latency(RT,  6'b000000, 3, "rtype_badfunct");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
